// File: rtl/regb_fifo_pkg.sv
// Shared definitions for the register-based FIFO serial transmitter:
// FSM state encodings and the frame-length helper.
package regb_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Total clk cycles occupied by one frame on txd.
  function automatic int frame_len(input int width, input int parity_en,
                                   input int stop_bits, input int clks_per_bit);
    return (1 + width + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/regb_bit_timer.sv
// Bit-period down-counter: bit_end_o marks the last cycle of the current bit
// period; restart_i reloads it for a full CLKS_PER_BIT period.
module regb_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic res,
  input  logic restart_i,
  output logic bit_end_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q <= '0;
    end else if (restart_i) begin
      cnt_q <= CW'(CLKS_PER_BIT - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign bit_end_o = (cnt_q == '0);

endmodule

// File: rtl/regb_fifo_serial_tx.sv
// Read side of the register-based FIFO: pops words from a fall-through FIFO
// and sends each LSB-first as a UART-style frame (start, data, parity, stop).
module regb_fifo_serial_tx
  import regb_fifo_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             enable,
  input  logic [WIDTH-1:0] rdata,
  input  logic             empty,
  output logic             shift_out,
  output logic             txd,
  output logic             busy,
  output logic             frame_done
);

  localparam int BCW = $clog2(WIDTH + 2);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             par_q, par_d;
  logic             txd_q, txd_d;
  logic             busy_q;
  logic             bit_end;
  logic             last_stop;
  logic             pop;
  logic             restart;

  assign last_stop = (state_q == ST_STOP) && bit_end && (bit_cnt_q == BCW'(STOP_BITS - 1));
  // A pop is allowed from IDLE or in the very last stop cycle, never while reset is held.
  assign pop       = !res && enable && !empty && ((state_q == ST_IDLE) || last_stop);
  assign restart   = pop || (bit_end && (state_q != ST_IDLE));

  regb_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .res      (res),
    .restart_i(restart),
    .bit_end_o(bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d   = ST_START;
          shreg_d   = rdata;
          par_d     = 1'b0;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          par_d   = par_q ^ shreg_q[0];
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BCW'(WIDTH - 1)) begin
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (last_stop) begin
          if (pop) begin
            state_d   = ST_START;
            shreg_d   = rdata;
            par_d     = 1'b0;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // txd is registered from the next state so the line never glitches.
    txd_d = 1'b1;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
      ST_PARITY: txd_d = par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      txd_q     <= txd_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign shift_out  = pop;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = last_stop;

endmodule

// File: tb/tb_regb_fifo_serial_tx.sv
// Self-checking bench: two transmitter configurations fed from queue-modelled
// FIFOs, compared every cycle against a frame-level reference model.
module tb_regb_fifo_serial_tx;
  import regb_fifo_pkg::*;

  localparam int W   = 4;
  localparam int CPB = 4;
  localparam int LA  = frame_len(W, 1, 1, CPB);
  localparam int LB  = frame_len(W, 0, 2, CPB);

  logic       clk = 1'b0;
  logic       res;
  logic       enA, enB;
  logic       emptyA, emptyB;
  logic [3:0] rdataA, rdataB;
  logic       shiftA, txdA, busyA, fdA;
  logic       shiftB, txdB, busyB, fdB;

  logic [3:0] qA[$];
  logic [3:0] qB[$];
  int         remA, remB;
  logic [3:0] wA, wB;
  int         nChecks, nFails, cyc;

  always #5 clk = ~clk;

  regb_fifo_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dutA (
    .clk(clk), .res(res), .enable(enA), .rdata(rdataA), .empty(emptyA),
    .shift_out(shiftA), .txd(txdA), .busy(busyA), .frame_done(fdA)
  );

  regb_fifo_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dutB (
    .clk(clk), .res(res), .enable(enB), .rdata(rdataB), .empty(emptyB),
    .shift_out(shiftB), .txd(txdB), .busy(busyB), .frame_done(fdB)
  );

  task automatic checkOutput(input string tag, input logic got, input logic exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, got, exp);
    end
  endtask

  // Line level of frame bit number idx: start, LSB-first data, optional even parity, stop.
  function automatic logic frameBit(input logic [3:0] w, input int idx, input bit parEn);
    if (idx == 0) return 1'b0;
    if (idx <= W) return w[idx-1];
    if (parEn && idx == W + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic checkInst(input string nm, input bit parEn, input int len,
                           input logic popO, input logic txdO, input logic busyO, input logic fdO,
                           input logic en, input int qsize, input int rem, input logic [3:0] w,
                           output bit expPop);
    bit active;
    logic expTxd;
    active = (rem > 0);
    expPop = !res && en && (qsize > 0) && (rem <= 1);
    expTxd = active ? frameBit(w, (len - rem) / CPB, parEn) : 1'b1;
    checkOutput({nm, ".shift_out"}, popO, expPop);
    checkOutput({nm, ".txd"}, txdO, expTxd);
    checkOutput({nm, ".busy"}, busyO, active);
    checkOutput({nm, ".frame_done"}, fdO, rem == 1);
  endtask

  task automatic syncFifo();
    emptyA = (qA.size() == 0);
    rdataA = emptyA ? 4'($urandom) : qA[0];
    emptyB = (qB.size() == 0);
    rdataB = emptyB ? 4'($urandom) : qB[0];
  endtask

  task automatic runCycle();
    bit pA, pB;
    if (res) begin
      remA = 0;
      remB = 0;
    end
    @(negedge clk);
    checkInst("A", 1'b1, LA, shiftA, txdA, busyA, fdA, enA, qA.size(), remA, wA, pA);
    checkInst("B", 1'b0, LB, shiftB, txdB, busyB, fdB, enB, qB.size(), remB, wB, pB);
    @(posedge clk);
    cyc++;
    if (res) remA = 0;
    else if (pA) begin wA = qA.pop_front(); remA = LA; end
    else if (remA > 0) remA--;
    if (res) remB = 0;
    else if (pB) begin wB = qB.pop_front(); remB = LB; end
    else if (remB > 0) remB--;
    #1 syncFifo();
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  initial begin
    nChecks = 0; nFails = 0; cyc = 0;
    remA = 0; remB = 0; wA = '0; wB = '0;
    res = 1'b1; enA = 1'b0; enB = 1'b0;
    syncFifo();
    applyStimulus(2);
    res = 1'b0;

    // single word 4'hA
    qA.push_back(4'hA); enA = 1'b1; syncFifo();
    applyStimulus(32);

    // back-to-back 4'h3, 4'h7
    qA.push_back(4'h3); qA.push_back(4'h7); syncFifo();
    applyStimulus(60);

    // enabled with an empty FIFO
    applyStimulus(50);

    // enable dropped during DATA of 4'h5 with 4'h9 still queued
    qA.push_back(4'h5); qA.push_back(4'h9); syncFifo();
    applyStimulus(10);
    enA = 1'b0;
    applyStimulus(30);

    // reset in the middle of the frame carrying 4'h9, then 4'hC goes out cleanly
    qA.push_back(4'hC); enA = 1'b1; syncFifo();
    applyStimulus(10);
    res = 1'b1;
    applyStimulus(3);
    res = 1'b0;
    applyStimulus(60);

    // no-parity, two-stop configuration with 4'hF
    qB.push_back(4'hF); enB = 1'b1; syncFifo();
    applyStimulus(32);

    // randomized traffic, enable toggling and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0 && qA.size() < 4) qA.push_back(4'($urandom));
      if ($urandom_range(0, 4) == 0 && qB.size() < 4) qB.push_back(4'($urandom));
      if ($urandom_range(0, 22) == 0) enA = ~enA;
      if ($urandom_range(0, 22) == 0) enB = ~enB;
      res = ($urandom_range(0, 399) == 0);
      syncFifo();
      runCycle();
    end

    res = 1'b0; enA = 1'b0; enB = 1'b0;
    applyStimulus(80);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
